// File: rtl/slave_spi_capture.sv
// Slave-side SPI pin capture: synchronises the raw bus into pclk, deserialises MOSI/MISO
// into words framed by CS, and queues completed word pairs in a small FIFO.
module slave_spi_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            pclk,
  input  logic                            areset,
  input  logic                            sclk,
  input  logic                            cs,
  input  logic                            mosi0,
  input  logic                            miso0,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic [DATA_WIDTH-1:0]           mosi_word,
  output logic [DATA_WIDTH-1:0]           miso_word,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            partial_err,
  output logic                            frame_done,
  output logic [15:0]                     frame_words,
  output logic                            busy
);

  localparam int   PTR_W    = $clog2(FIFO_DEPTH);
  localparam int   CNT_W    = PTR_W + 1;
  localparam int   BIT_W    = $clog2(DATA_WIDTH);
  localparam logic IDLE_LVL = 1'(CPOL);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  // Places a new bit into a word according to the configured bit order.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                      input logic b);
    if (MSB_FIRST != 0)
      shift_in = {sr[DATA_WIDTH-2:0], b};
    else
      shift_in = {b, sr[DATA_WIDTH-1:1]};
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_p0;
  logic [SYNC_STAGES-1:0] cs_sync_p0;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic [SYNC_STAGES-1:0] miso_sync_p0;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   miso_s;
  logic                   sclk_d;

  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;

  state_t                 state;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  mosi_sr_p1;
  logic [DATA_WIDTH-1:0]  miso_sr_p1;
  logic                   shift_now;
  logic                   push_now;
  logic [DATA_WIDTH-1:0]  push_mosi;
  logic [DATA_WIDTH-1:0]  push_miso;

  logic [DATA_WIDTH-1:0]  mosi_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  miso_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full;
  logic                   pop;
  logic                   push_ok;

  // Stage p0: raw pins into the pclk domain
  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_sync_p0 <= '0;
      cs_sync_p0   <= '0;
      mosi_sync_p0 <= '0;
      miso_sync_p0 <= '0;
      sclk_d       <= 1'b0;
    end else begin
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk};
      cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi0};
      miso_sync_p0 <= {miso_sync_p0[SYNC_STAGES-2:0], miso0};
      sclk_d       <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
  assign cs_s   = cs_sync_p0[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];
  assign miso_s = miso_sync_p0[SYNC_STAGES-1];

  always_comb begin
    lead_edge   = (sclk_d == IDLE_LVL) && (sclk_s != IDLE_LVL);
    trail_edge  = (sclk_d != IDLE_LVL) && (sclk_s == IDLE_LVL);
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  end

  // A CS rise takes priority over a coincident sample edge.
  always_comb begin
    shift_now = (state == ST_SHIFT) && !cs_s && sample_edge;
    push_now  = shift_now && (bit_cnt == LAST_BIT);
    push_mosi = shift_in(mosi_sr_p1, mosi_s);
    push_miso = shift_in(miso_sr_p1, miso_s);
  end

  // Stage p1: frame FSM and deserialiser
  always_ff @(posedge pclk) begin
    if (areset) begin
      state       <= ST_RESYNC;
      bit_cnt     <= '0;
      frame_words <= '0;
      frame_done  <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      partial_err <= 1'b0;
      case (state)
        ST_RESYNC: begin
          if (cs_s) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!cs_s) begin
            state       <= ST_SHIFT;
            bit_cnt     <= '0;
            frame_words <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            state       <= ST_IDLE;
            frame_done  <= 1'b1;
            partial_err <= (bit_cnt != '0);
          end else if (sample_edge) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (frame_words != 16'hFFFF) frame_words <= frame_words + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (shift_now) begin
      mosi_sr_p1 <= push_mosi;
      miso_sr_p1 <= push_miso;
    end
  end

  assign busy = (state == ST_SHIFT);

  // Stage p2: word FIFO
  always_comb begin
    fifo_full = (count == FULL_CNT);
    pop       = word_valid && word_ready;
    push_ok   = push_now && (!fifo_full || pop);
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_now && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (push_ok) begin
      mosi_mem[wr_ptr] <= push_mosi;
      miso_mem[wr_ptr] <= push_miso;
    end
  end

  // Head is gated so an empty FIFO never exposes stale or uninitialised storage.
  assign word_valid = (count != '0);
  assign fifo_count = count;
  assign mosi_word  = word_valid ? mosi_mem[rd_ptr] : '0;
  assign miso_word  = word_valid ? miso_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_slave_spi_capture.sv
// Directed/randomised bench for slave_spi_capture: a mode-0 MSB-first instance plus
// CPOL=1/CPHA=1 instances in both bit orders, checked against a queue-based word model.
module tb_slave_spi_capture;

  logic       pclk = 1'b0;
  logic       areset;

  logic       sclk0, cs0, mo0, mi0, rdy0;
  logic       v0, ovf0, pe0, fd0, busy0;
  logic [7:0] mw0, sw0;
  logic [2:0] cnt0;
  logic [15:0] fw0;

  logic       sclk3, cs3, mo3, mi3, rdy3;
  logic       va, ovfa, pea, fda, busya;
  logic [7:0] mwa, swa;
  logic [2:0] cnta;
  logic [15:0] fwa;
  logic       vb, ovfb, peb, fdb, busyb;
  logic [7:0] mwb, swb;
  logic [2:0] cntb;
  logic [15:0] fwb;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;

  logic [7:0] qm[$];
  logic [7:0] qs[$];
  logic       movf = 1'b0;

  always #5 pclk = ~pclk;

  slave_spi_capture #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1),
                      .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut0 (
    .pclk(pclk), .areset(areset), .sclk(sclk0), .cs(cs0), .mosi0(mo0), .miso0(mi0),
    .word_valid(v0), .word_ready(rdy0), .mosi_word(mw0), .miso_word(sw0),
    .fifo_count(cnt0), .overflow(ovf0), .partial_err(pe0), .frame_done(fd0),
    .frame_words(fw0), .busy(busy0));

  slave_spi_capture #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1),
                      .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut3m (
    .pclk(pclk), .areset(areset), .sclk(sclk3), .cs(cs3), .mosi0(mo3), .miso0(mi3),
    .word_valid(va), .word_ready(rdy3), .mosi_word(mwa), .miso_word(swa),
    .fifo_count(cnta), .overflow(ovfa), .partial_err(pea), .frame_done(fda),
    .frame_words(fwa), .busy(busya));

  slave_spi_capture #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0),
                      .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut3l (
    .pclk(pclk), .areset(areset), .sclk(sclk3), .cs(cs3), .mosi0(mo3), .miso0(mi3),
    .word_valid(vb), .word_ready(rdy3), .mosi_word(mwb), .miso_word(swb),
    .fifo_count(cntb), .overflow(ovfb), .partial_err(peb), .frame_done(fdb),
    .frame_words(fwb), .busy(busyb));

  // Every high cycle counts, so a stretched pulse shows up as an extra count.
  always @(negedge pclk) begin
    if (fd0) fd_cnt++;
    if (pe0) pe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Word as seen by an LSB-first receiver: the first bit on the wire ends up in bit 0.
  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7 - i];
    return r;
  endfunction

  task automatic mpush(input logic [7:0] m, input logic [7:0] s);
    if (qm.size() < 4) begin
      qm.push_back(m);
      qs.push_back(s);
    end else begin
      movf = 1'b1;
    end
  endtask

  task automatic bit0(input logic m, input logic s);
    mo0 = m; mi0 = s;
    tick(4);
    sclk0 = 1'b1;
    tick(4);
    sclk0 = 1'b0;
  endtask

  task automatic word0(input logic [7:0] m, input logic [7:0] s);
    for (int i = 7; i >= 0; i--) bit0(m[i], s[i]);
  endtask

  task automatic cs_lo0();
    cs0 = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi0();
    tick(4);
    cs0 = 1'b1;
    tick(8);
  endtask

  task automatic pop0(input string tag);
    logic [7:0] em, es;
    em = qm.pop_front();
    es = qs.pop_front();
    check({tag, ".valid"}, v0, 1);
    check({tag, ".mosi"}, mw0, em);
    check({tag, ".miso"}, sw0, es);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
  endtask

  task automatic word3(input logic [7:0] m, input logic [7:0] s);
    for (int i = 7; i >= 0; i--) begin
      sclk3 = 1'b0;
      mo3 = m[i]; mi3 = s[i];
      tick(4);
      sclk3 = 1'b1;
      tick(4);
    end
  endtask

  initial begin
    logic [7:0] m, s, m2, s2, nm, ns;
    int k, n, fd_b, pe_b;

    areset = 1'b1;
    sclk0 = 1'b0; cs0 = 1'b1; mo0 = 1'b0; mi0 = 1'b0; rdy0 = 1'b0;
    sclk3 = 1'b1; cs3 = 1'b1; mo3 = 1'b0; mi3 = 1'b0; rdy3 = 1'b0;
    tick(3);
    check("rst.valid", v0, 0);
    check("rst.count", cnt0, 0);
    check("rst.overflow", ovf0, 0);
    check("rst.frame_words", fw0, 0);
    check("rst.busy", busy0, 0);
    check("rst.mosi_word", mw0, 0);
    check("rst.miso_word", sw0, 0);
    areset = 1'b0;
    tick(6);

    // Test 1: single word A5/3C with latency check on the final sample edge
    m = 8'hA5; s = 8'h3C;
    mpush(m, s);
    cs_lo0();
    for (int i = 7; i >= 1; i--) bit0(m[i], s[i]);
    check("t1.busy", busy0, 1);
    mo0 = m[0]; mi0 = s[0];
    tick(4);
    sclk0 = 1'b1;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!v0 && k < 8);
    check("t1.latency", k, 3);
    if (k < 4) tick(4 - k);
    sclk0 = 1'b0;
    cs_hi0();
    check("t1.frame_done", fd_cnt, 1);
    check("t1.partial_err", pe_cnt, 0);
    check("t1.frame_words", fw0, 1);
    check("t1.count", cnt0, 1);
    check("t1.busy_after", busy0, 0);
    pop0("t1.pop");
    check("t1.empty_valid", v0, 0);
    check("t1.empty_head", mw0, 0);

    // Test 2: 5 words into a 4-deep FIFO with no consumer
    cs_lo0();
    for (int w = 1; w <= 5; w++) begin
      s = 8'($urandom);
      mpush(8'(w), s);
      word0(8'(w), s);
    end
    cs_hi0();
    check("t2.count", cnt0, 4);
    check("t2.overflow", ovf0, movf);
    check("t2.frame_words", fw0, 5);
    for (int i = 0; i < 4; i++) pop0("t2.pop");
    check("t2.count_after", cnt0, 0);

    // Random multi-word frames
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 3);
      fd_b = fd_cnt;
      cs_lo0();
      for (int w = 0; w < n; w++) begin
        m = 8'($urandom); s = 8'($urandom);
        mpush(m, s);
        word0(m, s);
      end
      cs_hi0();
      check("rnd.frame_words", fw0, n);
      check("rnd.count", cnt0, n);
      check("rnd.frame_done", fd_cnt, fd_b + 1);
      for (int w = 0; w < n; w++) pop0("rnd.pop");
    end

    // Test 3: CS rises after 5 bits
    fd_b = fd_cnt; pe_b = pe_cnt;
    cs_lo0();
    for (int i = 0; i < 5; i++) bit0(1'($urandom), 1'($urandom));
    cs_hi0();
    check("t3.partial_err", pe_cnt, pe_b + 1);
    check("t3.frame_done", fd_cnt, fd_b + 1);
    check("t3.frame_words", fw0, 0);
    check("t3.count", cnt0, 0);

    // Test 5: reset three bits into a frame, rest of that frame must be ignored
    fd_b = fd_cnt; pe_b = pe_cnt;
    cs_lo0();
    for (int i = 0; i < 3; i++) bit0(1'($urandom), 1'($urandom));
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    movf = 1'b0;
    check("t5.rst_count", cnt0, 0);
    check("t5.rst_overflow", ovf0, 0);
    check("t5.rst_frame_words", fw0, 0);
    check("t5.rst_busy", busy0, 0);
    for (int i = 0; i < 13; i++) bit0(1'($urandom), 1'($urandom));
    check("t5.resync_busy", busy0, 0);
    cs_hi0();
    check("t5.count", cnt0, 0);
    check("t5.valid", v0, 0);
    check("t5.no_frame_done", fd_cnt, fd_b);
    check("t5.no_partial", pe_cnt, pe_b);
    s = 8'($urandom);
    mpush(8'h5A, s);
    cs_lo0();
    word0(8'h5A, s);
    cs_hi0();
    check("t5.frame_words", fw0, 1);
    pop0("t5.pop");

    // Test 6: push into a full FIFO on the same cycle as a pop
    cs_lo0();
    for (int w = 0; w < 4; w++) begin
      m = 8'($urandom); s = 8'($urandom);
      mpush(m, s);
      word0(m, s);
    end
    cs_hi0();
    check("t6.full_count", cnt0, 4);
    nm = 8'($urandom); ns = 8'($urandom);
    cs_lo0();
    for (int i = 7; i >= 1; i--) bit0(nm[i], ns[i]);
    mo0 = nm[0]; mi0 = ns[0];
    tick(4);
    sclk0 = 1'b1;
    tick(2);
    m2 = qm.pop_front(); s2 = qs.pop_front();
    check("t6.head_mosi", mw0, m2);
    check("t6.head_miso", sw0, s2);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    mpush(nm, ns);
    check("t6.count", cnt0, 4);
    check("t6.overflow", ovf0, movf);
    tick(1);
    sclk0 = 1'b0;
    cs_hi0();
    for (int i = 0; i < 4; i++) pop0("t6.pop");
    check("t6.overflow_end", ovf0, 0);
    check("t6.count_end", cnt0, 0);

    // Test 4: CPOL=1/CPHA=1, both bit orders, 0x81 then a random word
    s  = 8'($urandom);
    m2 = 8'($urandom); s2 = 8'($urandom);
    cs3 = 1'b0;
    tick(4);
    word3(8'h81, s);
    word3(m2, s2);
    tick(4);
    cs3 = 1'b1;
    tick(8);
    check("t4.msb_count", cnta, 2);
    check("t4.lsb_count", cntb, 2);
    check("t4.msb_frame_words", fwa, 2);
    check("t4.msb_mosi0", mwa, 8'h81);
    check("t4.msb_miso0", swa, s);
    check("t4.lsb_mosi0", mwb, 8'h81);
    check("t4.lsb_miso0", swb, rev8(s));
    rdy3 = 1'b1;
    tick(1);
    rdy3 = 1'b0;
    check("t4.msb_mosi1", mwa, m2);
    check("t4.msb_miso1", swa, s2);
    check("t4.lsb_mosi1", mwb, rev8(m2));
    check("t4.lsb_miso1", swb, rev8(s2));
    rdy3 = 1'b1;
    tick(1);
    rdy3 = 1'b0;
    check("t4.msb_empty", va, 0);
    check("t4.lsb_empty", vb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
